gray_conv_scheduler: RTL and testbench

//   Shares one binary-to-Gray converter (4-bit, F = B ^ (B >> 1)) between NREQ requesters.
//   A round-robin arbiter accepts one request per cycle over a valid/ready handshake.
//   It converts the request's data and returns a registered result tagged with the requester ID.

---
 rtl/gray_conv_scheduler_pkg.sv | 27 ++
 rtl/gray_conv_scheduler_rr_arbiter.sv | 35 +++
 rtl/gray_conv_scheduler.sv | 100 ++++++++++
 tb/tb_gray_conv_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_scheduler_pkg.sv
// Shared definitions for the Gray-conversion scheduler: code converters,
// default ID width and FSM state encoding.
package gray_pkg;

    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Callers truncate the 32-bit result to their own word width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    always_comb begin
        int   idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int off = 0; off < NREQ; off++) begin
            // Explicit wrap keeps non-power-of-two NREQ correct.
            idx = int'(ptr_i) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/gray_conv_scheduler.sv
// Shares one binary-to-Gray converter between NREQ requesters via round-robin;
// registered result one cycle after accept, with same-cycle drain+accept.
module gray_conv_scheduler
    import gray_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WIDTH   = 4,
    parameter  int COUNT_W = 8,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  busy,
    output logic [COUNT_W-1:0]    conv_count
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [IDW-1:0]       out_id_q, out_id_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [COUNT_W-1:0]   count_q, count_d;

    logic                 can_accept;
    logic                 accept;
    logic                 drain;
    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       grant_idx;
    logic [WIDTH-1:0]     sel_data;

    assign can_accept = (state_q == ST_IDLE) | out_ready;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .enable_i    (can_accept & rst_n),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign accept   = |grant;
    assign drain    = (state_q == ST_FULL) & out_ready;
    assign sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        count_d    = count_q;

        if (accept) begin
            state_d    = ST_FULL;
            out_data_d = WIDTH'(bin2gray(32'(sel_data)));
            out_id_d   = grant_idx;
            if (int'(grant_idx) == NREQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDW'(1);
            end
        end else if (drain) begin
            state_d = ST_IDLE;
        end

        if (drain && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
            count_q    <= count_d;
        end
    end

    assign req_ready  = grant;
    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign busy       = out_valid | (|req_valid);
    assign conv_count = count_q;

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Directed and random checks of gray_conv_scheduler against a cycle-level reference model.
module tb_gray_conv_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        busy;
    logic [7:0]  conv_count;

    logic [1:0]  s_valid;
    logic [7:0]  s_data;
    logic [1:0]  s_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [3:0]  s_out_data;
    logic [0:0]  s_out_id;
    logic        s_busy;
    logic [1:0]  s_count;

    gray_conv_scheduler #(.NREQ(4), .WIDTH(4), .COUNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy), .conv_count(conv_count)
    );

    gray_conv_scheduler #(.NREQ(2), .WIDTH(4), .COUNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_data(s_data),
        .req_ready(s_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_id(s_out_id), .busy(s_busy), .conv_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: the result slot, the next-search position, the drain count.
    bit         m_valid;
    logic [3:0] m_data;
    int         m_id;
    int         m_ptr;
    int         m_count;
    logic [3:0] obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_gray(input logic [3:0] b);
        logic [3:0] g;
        g[3] = b[3];
        for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    function automatic int model_grant(input logic [3:0] v, input int ptr, input bit can);
        if (!can) return -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 4'd0;
        m_id    = 0;
        m_ptr   = 0;
        m_count = 0;
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic step();
        int         g;
        logic [3:0] er;
        g  = model_grant(req_valid, m_ptr, !m_valid || out_ready);
        er = 4'd0;
        if (g >= 0) er[g] = 1'b1;
        #1;
        obs_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_id", 32'(out_id), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_valid | (|req_valid)));
        chk("conv_count", 32'(conv_count), 32'(m_count));
        @(posedge clk);
        if (m_valid && out_ready && m_count != 255) m_count++;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = ref_gray(req_data[g*4 +: 4]);
            m_id    = g;
            m_ptr   = (g + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int         exp_sat   [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_n       = 1'b0;
        req_valid   = 4'b0010;
        req_data    = 16'h0060;
        out_ready   = 1'b0;
        s_valid     = 2'b00;
        s_data      = 8'h00;
        s_out_ready = 1'b0;
        model_reset();

        // Reset state while a request is already asserted
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_count", 32'(conv_count), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 1
        step();
        chk("t1_grant", 32'(obs_rdy), 32'b0010);
        chk("t1_out_valid", 32'(out_valid), 32'h1);
        chk("t1_out_data", 32'(out_data), 32'b0101);
        chk("t1_out_id", 32'(out_id), 32'h1);
        req_valid = 4'b0000;
        out_ready = 1'b1;
        step();

        // Round-robin fairness from a fresh pointer
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_data = 16'($urandom);
            step();
            chk("rr_order", 32'(obs_rdy), 32'(exp_order[i]));
        end
        req_valid = 4'b0000;
        step();
        chk("rr_count", 32'(conv_count), 32'd8);

        // Backpressure: hold 1111 -> 1000 for five cycles
        req_valid = 4'b0001;
        req_data  = 16'h000F;
        out_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rdy", 32'(obs_rdy), 32'h0);
            chk("bp_data", 32'(out_data), 32'b1000);
            chk("bp_id", 32'(out_id), 32'h0);
        end
        out_ready = 1'b1;
        req_valid = 4'b0000;
        step();

        // Pass-through: drain and accept in the same cycle
        req_valid = 4'b0001;
        req_data  = 16'h0003;
        step();
        req_valid = 4'b1000;
        req_data  = 16'hA000;
        step();
        chk("pt_grant", 32'(obs_rdy), 32'b1000);
        chk("pt_data", 32'(out_data), 32'b1111);
        chk("pt_id", 32'(out_id), 32'h3);
        req_valid = 4'b0001;
        step();
        chk("pt_nobubble", 32'(obs_rdy), 32'b0001);

        // Random traffic, including withdrawn requests
        for (int i = 0; i < 300; i++) begin
            req_valid = 4'($urandom);
            req_data  = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Asynchronous reset between edges while a result is held
        req_valid = 4'b1111;
        out_ready = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_req_ready", 32'(req_ready), 32'h0);
        chk("mr_count", 32'(conv_count), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        out_ready = 1'b1;
        step();
        chk("mr_first_grant", 32'(obs_rdy), 32'b0010);
        req_valid = 4'b0000;
        step();

        // Saturating counter on the COUNT_W=2 instance
        s_valid     = 2'b01;
        s_data      = 8'h05;
        s_out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sat_count", 32'(s_count), 32'(exp_sat[i]));
        end
        chk("sat_data", 32'(s_out_data), 32'(ref_gray(4'h5)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
